// File: rtl/bsg_counter_up_down_sat_load_if.sv
// Control/status bundle for bsg_counter_up_down_sat_load: step/load/clear requests in,
// registered count and sticky flags out.
interface bsg_counter_up_down_sat_load_if #(
  parameter int width_p      = 64,
  parameter int step_width_p = 1
);
  logic                    clear_i;
  logic                    load_v_i;
  logic [width_p-1:0]      load_val_i;
  logic [step_width_p-1:0] up_i;
  logic [step_width_p-1:0] down_i;
  logic [width_p-1:0]      count_o;
  logic                    overflow_o;
  logic                    underflow_o;
  logic                    zero_o;
  logic                    max_o;

  modport master (
    output clear_i, load_v_i, load_val_i, up_i, down_i,
    input  count_o, overflow_o, underflow_o, zero_o, max_o
  );

  modport slave (
    input  clear_i, load_v_i, load_val_i, up_i, down_i,
    output count_o, overflow_o, underflow_o, zero_o, max_o
  );
endinterface

// File: rtl/bsg_counter_up_down_sat_load.sv
// Up/down counter with load, clear, wrap-or-saturate result and sticky over/underflow flags.
// The step result is formed exactly in width_p+2 bits so range violations are never lost.
module bsg_counter_up_down_sat_load #(
  parameter int                 width_p      = 64,
  parameter logic [width_p-1:0] init_val_p   = '0,
  parameter int                 step_width_p = 1,
  parameter bit                 saturate_p   = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  bsg_counter_up_down_sat_load_if.slave bus
);
  localparam int sw_lp = width_p + 2;

  logic [width_p-1:0] count_r;
  logic               ovf_r, unf_r;
  logic [width_p-1:0] base;
  logic [sw_lp-1:0]   sum;
  logic               sum_neg, sum_big;
  logic [width_p-1:0] next_count;

  // Top bit is the sign; bit width_p set on a non-negative sum means > 2^width_p-1.
  always_comb begin
    base       = bus.clear_i ? init_val_p : count_r;
    sum        = sw_lp'(base) + sw_lp'(bus.up_i) - sw_lp'(bus.down_i);
    sum_neg    = sum[sw_lp-1];
    sum_big    = ~sum_neg & sum[width_p];
    next_count = sum[width_p-1:0];
    if (saturate_p) begin
      if (sum_big)      next_count = '1;
      else if (sum_neg) next_count = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_r <= init_val_p;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else if (bus.load_v_i && !bus.clear_i) begin
      count_r <= bus.load_val_i;
    end else begin
      count_r <= next_count;
      ovf_r   <= (ovf_r & ~bus.clear_i) | sum_big;
      unf_r   <= (unf_r & ~bus.clear_i) | sum_neg;
    end
  end

  assign bus.count_o     = count_r;
  assign bus.overflow_o  = ovf_r;
  assign bus.underflow_o = unf_r;
  assign bus.zero_o      = (count_r == '0);
  assign bus.max_o       = &count_r;
endmodule
